// File: rtl/cpu_dtack_gen.sv
// M68K DTACK/BERR generator: per-region wait states, ROM data-ready wait, shared-RAM arbitration hold.
// Optional bus-error timeout when CPU_BERR_TIMEOUT_EN is defined; otherwise unmapped accesses read open bus.
module cpu_dtack_gen #(
  parameter int RAM_WAIT    = 1,
  parameter int SHARED_WAIT = 3,
  parameter int IO_WAIT     = 2
`ifdef CPU_BERR_TIMEOUT_EN
  , parameter int TIMEOUT   = 255
`endif
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       cpu_as_n,
  input  logic       cpu_rw,
  input  logic       prog_rom_cs,
  input  logic       ram_cs,
  input  logic       shared_ram_cs,
  input  logic       pal_cs,
  input  logic       io_cs,
  input  logic       prog_rom_valid,
  input  logic       shared_busy,
  output logic       dtack_n,
  output logic       berr_n,
  output logic [1:0] bus_state
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_ACK = 2'd2, S_BERR = 2'd3} state_t;
  typedef enum logic [2:0] {RG_NONE, RG_ROM, RG_RAM, RG_SHR, RG_IO} region_t;

  state_t     r_state, w_next;
  region_t    r_region, w_region;
  logic       r_as_n;
  logic [7:0] r_cnt, w_load;
  logic       w_start, w_zero, w_cnt_done;

  assign w_start    = !cpu_as_n && r_as_n;
  // Counter holds W on WAIT entry, so the final WAIT cycle is the one showing 1 (or 0 once saturated).
  assign w_cnt_done = (r_cnt <= 8'd1);

`ifdef CPU_BERR_TIMEOUT_EN
  logic [7:0] r_tmo;
  logic       w_tmo_hit;
  assign w_tmo_hit = (r_tmo == 8'(TIMEOUT - 1));
`endif

  always_comb begin
`ifdef CPU_BERR_TIMEOUT_EN
    w_region = RG_NONE;
    w_load   = '0;
`else
    w_region = RG_IO;
    w_load   = 8'(IO_WAIT);
`endif
    if (prog_rom_cs) begin
      w_region = RG_ROM;
      w_load   = '0;
    end else if (ram_cs) begin
      w_region = RG_RAM;
      w_load   = 8'(RAM_WAIT);
    end else if (shared_ram_cs) begin
      w_region = RG_SHR;
      w_load   = 8'(SHARED_WAIT);
    end else if (pal_cs || io_cs) begin
      w_region = RG_IO;
      w_load   = 8'(IO_WAIT);
    end
    case (w_region)
      RG_ROM:  w_zero = !cpu_rw;
      RG_NONE: w_zero = 1'b0;
      default: w_zero = (w_load == 8'd0);
    endcase
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_start) w_next = w_zero ? S_ACK : S_WAIT;
      S_WAIT: begin
        if (cpu_as_n) w_next = S_IDLE;
        else begin
          case (r_region)
            RG_ROM:        if (prog_rom_valid) w_next = S_ACK;
            RG_SHR:        if (w_cnt_done && !shared_busy) w_next = S_ACK;
            RG_RAM, RG_IO: if (w_cnt_done) w_next = S_ACK;
            default:       w_next = S_WAIT;
          endcase
`ifdef CPU_BERR_TIMEOUT_EN
          if (w_next == S_WAIT && w_tmo_hit) w_next = S_BERR;
`endif
        end
      end
      S_ACK, S_BERR: if (cpu_as_n) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_region <= RG_NONE;
      r_as_n   <= 1'b1;
      r_cnt    <= '0;
    end else begin
      r_state <= w_next;
      r_as_n  <= cpu_as_n;
      if (r_state == S_IDLE && w_start) begin
        r_cnt    <= w_load;
        r_region <= w_region;
      end else if (r_state == S_WAIT && !cpu_as_n) begin
        if (r_cnt != 8'd0) r_cnt <= r_cnt - 8'd1;
      end else begin
        r_cnt <= '0;
      end
    end
  end

`ifdef CPU_BERR_TIMEOUT_EN
  always_ff @(posedge clk_sys) begin
    if (reset)                         r_tmo <= '0;
    else if (r_state == S_IDLE && w_start) r_tmo <= '0;
    else if (r_state == S_WAIT)        r_tmo <= r_tmo + 8'd1;
  end
  assign berr_n = (r_state != S_BERR);
`else
  assign berr_n = 1'b1;
`endif

  assign dtack_n   = (r_state != S_ACK);
  assign bus_state = r_state;

endmodule

// File: tb/tb_cpu_dtack_gen.sv
// Directed bench for cpu_dtack_gen: expected acknowledge cycles are queued at stimulus time
// and popped when dtack_n/berr_n fall.
module tb_cpu_dtack_gen;
  logic clk_sys = 1'b0, reset = 1'b1, cpu_as_n = 1'b1, cpu_rw = 1'b1;
  logic prog_rom_cs = 1'b0, ram_cs = 1'b0, shared_ram_cs = 1'b0, pal_cs = 1'b0, io_cs = 1'b0;
  logic prog_rom_valid = 1'b0, shared_busy = 1'b0;
  logic dtack_n, berr_n;
  logic [1:0] bus_state;

  typedef struct {string tag; int cyc; bit berr;} exp_t;
  exp_t q[$];
  int   cyc = 0;
  int   n_tests = 0, n_fail = 0, s = 0;
  logic prev_dt = 1'b1, prev_be = 1'b1;

  cpu_dtack_gen dut (
    .clk_sys(clk_sys), .reset(reset), .cpu_as_n(cpu_as_n), .cpu_rw(cpu_rw),
    .prog_rom_cs(prog_rom_cs), .ram_cs(ram_cs), .shared_ram_cs(shared_ram_cs),
    .pal_cs(pal_cs), .io_cs(io_cs), .prog_rom_valid(prog_rom_valid),
    .shared_busy(shared_busy), .dtack_n(dtack_n), .berr_n(berr_n), .bus_state(bus_state)
  );

  always #5 clk_sys = ~clk_sys;
  always @(posedge clk_sys) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic ev(input string kind, input bit is_berr);
    exp_t e;
    if (q.size() == 0) chk({kind, "_spurious_qsize"}, 32'(q.size()), 32'd1);
    else begin
      e = q.pop_front();
      chk({e.tag, "_cycle"}, 32'(cyc), 32'(e.cyc));
      chk({e.tag, "_kind"}, 32'(is_berr), 32'(e.berr));
    end
  endtask

  // One clock; outputs are sampled on the falling edge, where stimulus is also driven.
  task automatic tick();
    @(posedge clk_sys);
    @(negedge clk_sys);
    if (dtack_n === 1'b0 && prev_dt === 1'b1) ev("dtack", 1'b0);
    if (berr_n === 1'b0 && prev_be === 1'b1) ev("berr", 1'b1);
    chk("excl", 32'(dtack_n === 1'b0 && berr_n === 1'b0), 32'd0);
    prev_dt = dtack_n;
    prev_be = berr_n;
  endtask

  task automatic go(input logic [4:0] sel, input logic rw);
    {prog_rom_cs, ram_cs, shared_ram_cs, pal_cs, io_cs} = sel;
    cpu_rw   = rw;
    cpu_as_n = 1'b0;
    s        = cyc;
  endtask

  task automatic finish_acc(input string tag);
    cpu_as_n = 1'b1;
    {prog_rom_cs, ram_cs, shared_ram_cs, pal_cs, io_cs} = 5'b0;
    tick();
    chk({tag, "_rel_dtack"}, 32'(dtack_n), 32'd1);
    chk({tag, "_rel_berr"}, 32'(berr_n), 32'd1);
    chk({tag, "_rel_state"}, 32'(bus_state), 32'd0);
    chk({tag, "_pending"}, 32'(q.size()), 32'd0);
    tick();
  endtask

  initial begin
    repeat (3) tick();
    chk("rst_dtack", 32'(dtack_n), 32'd1);
    chk("rst_berr", 32'(berr_n), 32'd1);
    chk("rst_state", 32'(bus_state), 32'd0);
    reset = 1'b0;
    tick();

    // Work RAM: ack two cycles after the start, held while AS stays low
    go(5'b01000, 1'b1); q.push_back('{"ram", s + 2, 1'b0});
    repeat (5) tick();
    chk("ram_hold", 32'(dtack_n), 32'd0);
    chk("ram_state", 32'(bus_state), 32'd2);
    finish_acc("ram");

    // ROM read waits for the data-ready pulse at +7
    go(5'b10000, 1'b1); q.push_back('{"rom_rd", s + 8, 1'b0});
    repeat (7) tick();
    prog_rom_valid = 1'b1; tick(); prog_rom_valid = 1'b0;
    tick();
    finish_acc("rom_rd");

    // Stale pulse in IDLE must not complete the next access; ROM wins over RAM and IO
    prog_rom_valid = 1'b1; tick(); prog_rom_valid = 1'b0; tick();
    go(5'b11001, 1'b1); q.push_back('{"rom_prio", s + 4, 1'b0});
    repeat (3) tick();
    prog_rom_valid = 1'b1; tick(); prog_rom_valid = 1'b0;
    repeat (2) tick();
    finish_acc("rom_prio");

    // ROM write completes with zero wait
    go(5'b10000, 1'b0); q.push_back('{"rom_wr", s + 1, 1'b0});
    repeat (3) tick();
    finish_acc("rom_wr");

    // Shared RAM held by the sound CPU for 10 cycles
    go(5'b00100, 1'b1); shared_busy = 1'b1; q.push_back('{"shr_busy", s + 11, 1'b0});
    repeat (10) tick();
    shared_busy = 1'b0;
    repeat (3) tick();
    finish_acc("shr_busy");

    go(5'b00100, 1'b1); q.push_back('{"shr_free", s + 4, 1'b0});
    repeat (6) tick();
    finish_acc("shr_free");

    // RAM over palette and IO
    go(5'b01011, 1'b0); q.push_back('{"ram_prio", s + 2, 1'b0});
    repeat (4) tick();
    finish_acc("ram_prio");

    go(5'b00010, 1'b1); q.push_back('{"pal", s + 3, 1'b0});
    repeat (4) tick();
    finish_acc("pal");

    // IO access aborted one cycle in: no acknowledge at all
    go(5'b00001, 1'b1);
    tick();
    cpu_as_n = 1'b1; io_cs = 1'b0;
    tick();
    chk("abort_state", 32'(bus_state), 32'd0);
    chk("abort_dtack", 32'(dtack_n), 32'd1);
    repeat (4) tick();
    chk("abort_pending", 32'(q.size()), 32'd0);

    // Unmapped access
    go(5'b00000, 1'b1);
`ifdef CPU_BERR_TIMEOUT_EN
    q.push_back('{"unmapped_berr", s + 256, 1'b1});
    repeat (258) tick();
    chk("unmapped_dtack", 32'(dtack_n), 32'd1);
    chk("unmapped_berr_hold", 32'(berr_n), 32'd0);
`else
    q.push_back('{"unmapped_open", s + 3, 1'b0});
    repeat (4) tick();
`endif
    finish_acc("unmapped");

    // Reset while a palette access sits at counter 1
    go(5'b00010, 1'b1);
    repeat (2) tick();
    reset = 1'b1; cpu_as_n = 1'b1; pal_cs = 1'b0;
    tick();
    chk("rstmid_dtack", 32'(dtack_n), 32'd1);
    chk("rstmid_state", 32'(bus_state), 32'd0);
    reset = 1'b0;
    repeat (5) tick();
    chk("rstmid_dtack_after", 32'(dtack_n), 32'd1);
    chk("rstmid_pending", 32'(q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/cpu_dtack_gen.md
CPU_DTACK_GEN -- requirements
Module: cpu_dtack_gen

Interface
REQ-001 SHALL have parameter RAM_WAIT, default 1, wait cycles before DTACK for work RAM.
REQ-002 SHALL have parameter SHARED_WAIT, default 3, minimum wait cycles for the shared RAM window.
REQ-003 SHALL have parameter IO_WAIT, default 2, wait cycles for palette and I/O registers.
REQ-004 SHALL have parameter TIMEOUT, default 255, 8-bit cycle limit before a bus error (only when BERR_TIMEOUT_EN is defined).
REQ-005 SHALL have port clk_sys, input, 1, the single system clock; all logic on its rising edge.
REQ-006 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-007 SHALL have port cpu_as_n, input, 1, M68K address strobe, active low.
REQ-008 SHALL have port cpu_rw, input, 1, M68K read/write; 1 means read.
REQ-009 SHALL have ports prog_rom_cs, ram_cs, shared_ram_cs, pal_cs and io_cs, each an input of width 1, the region selects from the chip-select decoder.
REQ-010 SHALL have port prog_rom_valid, input, 1, a one-cycle pulse from the SDRAM controller when ROM read data is ready.
REQ-011 SHALL have port shared_busy, input, 1, asserted while the sound CPU owns the shared RAM port.
REQ-012 SHALL have port dtack_n, output, 1, data transfer acknowledge to the M68K, active low.
REQ-013 SHALL have port berr_n, output, 1, bus error to the M68K, active low.
REQ-014 SHALL have port bus_state, output, 2, the current FSM state encoding, for debug.

Function
REQ-015 SHALL implement the states IDLE=0, WAIT=1, ACK=2 and BERR=3.
REQ-016 SHALL register cpu_as_n each cycle and detect a cycle start when cpu_as_n=0 and the previous sample was 1.
REQ-017 SHALL, in IDLE on a cycle start, select the region by priority prog_rom > ram > shared > pal > io, load the wait counter (RAM_WAIT, SHARED_WAIT, or IO_WAIT; 0 for ROM) and enter WAIT.
REQ-018 SHALL, when more than one select is active, use the highest-priority region only, with no other effect.
REQ-019 SHALL, for a ROM read, remain in WAIT until prog_rom_valid=1, then enter ACK on the next edge.
REQ-020 SHALL, for a ROM write, treat the access as wait 0 and not wait for prog_rom_valid.
REQ-021 SHALL, for the other regions, decrement the counter each cycle in WAIT and enter ACK when the counter is 0.
REQ-022 SHALL, for the shared region, additionally hold WAIT while shared_busy=1, even when the counter is 0.
REQ-023 SHALL give a latency, with the cycle start detected at cycle N and wait W, of dtack_n=0 from cycle N+1+W.
REQ-024 SHALL, in ACK, hold dtack_n=0 until cpu_as_n=1 is sampled, then return to IDLE with dtack_n=1 on that same edge.
REQ-025 SHALL, if cpu_as_n rises while in WAIT (abort), return to IDLE without asserting dtack_n and discard the counter.
REQ-026 SHALL ignore a prog_rom_valid pulse that arrives in IDLE, and SHALL NOT let it satisfy the next access.
REQ-027 SHALL never assert dtack_n and berr_n in the same cycle.

Reset
REQ-028 SHALL, while reset=1, force state IDLE, counters to 0, dtack_n=1, berr_n=1, bus_state=0 and the registered cpu_as_n to 1.
REQ-029 SHALL abandon any access in progress when reset is asserted, with no acknowledge issued after reset releases.

Configuration
REQ-030 SHALL use the macro CPU_BERR_TIMEOUT_EN.
REQ-031 SHALL, when the macro is defined, run an 8-bit timeout counter that is cleared on a cycle start and increments in WAIT.
REQ-032 SHALL, when the macro is defined, enter BERR when the timeout counter equals TIMEOUT, then drive berr_n=0 until cpu_as_n=1 and return to IDLE.
REQ-033 SHALL, when the macro is defined, treat a cycle start with no select active as WAIT with no completion condition, so it always ends in BERR.
REQ-034 SHALL, when the macro is undefined, tie berr_n to 1, remove the timeout counter, and acknowledge an unmapped access as an io access with IO_WAIT (open bus).

Verification
REQ-035 SHALL cover: ram_cs=1, AS falls at cycle 10 with the defaults -> dtack_n=0 at cycle 12, held until AS rises, then 1 on the next edge.
REQ-036 SHALL cover: a prog_rom_cs read with prog_rom_valid pulsed at cycle +7 -> dtack_n=0 at cycle +8, with no earlier acknowledge.
REQ-037 SHALL cover: shared_ram_cs with shared_busy=1 for 10 cycles after the start -> dtack_n stays 1 until the cycle after shared_busy falls, and no earlier than cycle +4.
REQ-038 SHALL cover: io_cs, then AS rises at cycle +1 -> dtack_n never asserts and bus_state returns to 0.
REQ-039 SHALL cover: an unmapped access with the macro defined and TIMEOUT=255 -> berr_n=0 after 255 WAIT cycles while dtack_n stays 1; with the macro undefined -> dtack_n=0 at cycle +3.
REQ-040 SHALL cover: reset asserted at WAIT counter 1 of a pal_cs access -> dtack_n=1, bus_state=0, and no acknowledge after release.
